// File: rtl/evcnt_pkg.sv
// Shared types, constants and helpers for the event_counter_bcd block.
// Holds the BCD converter state encoding and the double-dabble digit correction.
package evcnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  localparam int SYNC_STAGES = 2;

  // Double-dabble correction: a digit of 5 or more would overflow past 9 once doubled.
  function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/dec_hex.sv
// BCD digit to seven-segment decoder for the lab board (segments active-low,
// bit order gfedcba). Non-decimal codes blank the digit.
module dec_hex (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_hex
);

  always_comb begin
    unique case (i_bcd)
      4'd0:    o_hex = 7'b1000000;
      4'd1:    o_hex = 7'b1111001;
      4'd2:    o_hex = 7'b0100100;
      4'd3:    o_hex = 7'b0110000;
      4'd4:    o_hex = 7'b0011001;
      4'd5:    o_hex = 7'b0010010;
      4'd6:    o_hex = 7'b0000010;
      4'd7:    o_hex = 7'b1111000;
      4'd8:    o_hex = 7'b0000000;
      4'd9:    o_hex = 7'b0010000;
      default: o_hex = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/key_cond.sv
// Key conditioning for one active-low pushbutton: 2-flop synchroniser,
// stable-level debounce and a one-cycle pulse on each accepted press.
module key_cond
  import evcnt_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;   // accepted level, 1 = released
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_press;
  logic                   w_sync_level;
  logic                   w_accept;

  assign w_sync_level = r_sync[SYNC_STAGES-1];
  assign w_accept     = (w_sync_level != r_level) && (r_db_cnt == DB_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '1;
      r_level  <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_key_n};
      r_press <= w_accept && !w_sync_level;
      if (w_sync_level == r_level) begin
        r_db_cnt <= '0;
      end else if (w_accept) begin
        r_level  <= w_sync_level;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/event_counter_bcd.sv
// Debounced press counter modulo MAX_COUNT+1 with sequential binary-to-BCD display.
// Define EVCNT_DOWN_EN to add the key_dec_i decrement key and its cancel logic.
module event_counter_bcd
  import evcnt_pkg::*;
#(
  parameter int  SW_W         = 10,
  parameter int  MAX_COUNT    = 255,
  parameter int  DIGITS       = 3,
  parameter int  DEBOUNCE_CYC = 1_000_000,
  localparam int CNT_W        = $clog2(MAX_COUNT + 1)
) (
  input  logic                  clk100_i,
  input  logic                  reset,
  input  logic                  key_inc_i,
`ifdef EVCNT_DOWN_EN
  input  logic                  key_dec_i,
`endif
  input  logic [SW_W-1:0]       sw_i,
  output logic [SW_W-1:0]       ledr_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [7*DIGITS-1:0]   hex_o,
  output logic                  busy_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SC_W  = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

  logic w_inc_press;
  logic w_step_up;
  logic w_step_dn;

  key_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_inc (
    .clk     (clk100_i),
    .rst_n   (reset),
    .i_key_n (key_inc_i),
    .o_press (w_inc_press)
  );

`ifdef EVCNT_DOWN_EN
  logic w_dec_press;

  key_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_dec (
    .clk     (clk100_i),
    .rst_n   (reset),
    .i_key_n (key_dec_i),
    .o_press (w_dec_press)
  );

  // Presses landing in the same cycle cancel each other out.
  assign w_step_up = w_inc_press & ~w_dec_press;
  assign w_step_dn = w_dec_press & ~w_inc_press;
`else
  assign w_step_up = w_inc_press;
  assign w_step_dn = 1'b0;
`endif

  logic [CNT_W-1:0] r_count;
  logic [SW_W-1:0]  r_ledr;
  logic             r_req;

  always_ff @(posedge clk100_i or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_ledr  <= '0;
      r_req   <= 1'b0;
    end else begin
      r_req <= w_step_up | w_step_dn;
      if (w_step_up) begin
        r_count <= (r_count == MAX_VAL) ? '0 : r_count + CNT_W'(1);
        r_ledr  <= sw_i;
      end else if (w_step_dn) begin
        r_count <= (r_count == '0) ? MAX_VAL : r_count - CNT_W'(1);
        r_ledr  <= sw_i;
      end
    end
  end

  // Double-dabble converter: shift the binary value MSB-first into the scratch BCD.
  bcd_state_e        r_state;
  bcd_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_bin;
  logic [BCD_W-1:0]  r_scratch;
  logic [SC_W-1:0]   r_shift_cnt;
  logic              r_pend;
  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  w_corrected;
  logic [BCD_W-1:0]  w_shifted;
  logic              w_load;
  logic              w_shift;
  logic              w_finish;

  always_comb begin
    w_corrected = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_corrected[4*d +: 4] = bcd_add3(r_scratch[4*d +: 4]);
    end
  end

  assign w_shifted = {w_corrected[BCD_W-2:0], r_bin[CNT_W-1]};

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_req) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_shift_cnt == SC_W'(1)) begin
          w_state_nxt = ST_DONE;
          w_finish    = 1'b1;
        end
      end
      ST_DONE: begin
        if (r_pend || r_req) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100_i or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_bin       <= '0;
      r_scratch   <= '0;
      r_shift_cnt <= '0;
      r_pend      <= 1'b0;
      r_bcd       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_bin       <= r_count;
        r_scratch   <= '0;
        r_shift_cnt <= SC_W'(CNT_W);
      end else if (w_shift) begin
        r_bin       <= r_bin << 1;
        r_scratch   <= w_shifted;
        r_shift_cnt <= r_shift_cnt - SC_W'(1);
      end
      if (w_finish) begin
        r_bcd <= w_shifted;
      end
      // A load always samples the latest count, so it absorbs any pending change.
      if (w_load) begin
        r_pend <= 1'b0;
      end else if (r_req) begin
        r_pend <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    dec_hex u_dec_hex (
      .i_bcd (r_bcd[4*g +: 4]),
      .o_hex (hex_o[7*g +: 7])
    );
  end

  assign count_o = r_count;
  assign ledr_o  = r_ledr;
  assign bcd_o   = r_bcd;
  assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_event_counter_bcd.sv
// Scoreboard bench for event_counter_bcd: stimulus pushes expected results,
// a negedge monitor pops and compares when each BCD conversion completes.
module tb_event_counter_bcd;

  localparam int SW_W      = 10;
  localparam int MAX_COUNT = 255;
  localparam int DIGITS    = 3;
  localparam int DEB       = 4;
  localparam int CNT_W     = 8;
  localparam int HOLD      = DEB + 8;

  typedef struct {
    int              count;
    logic [SW_W-1:0] ledr;
  } exp_t;

  logic clk      = 1'b0;
  logic reset    = 1'b0;
  logic key_inc  = 1'b1;
  logic key_fast = 1'b1;
  logic [SW_W-1:0] sw = '0;
`ifdef EVCNT_DOWN_EN
  logic key_dec  = 1'b1;
  logic key_decf = 1'b1;
`endif

  logic [SW_W-1:0]     ledr,   ledr_f;
  logic [CNT_W-1:0]    count,  count_f;
  logic [4*DIGITS-1:0] bcd,    bcd_f;
  logic [7*DIGITS-1:0] hex,    hex_f;
  logic                busy,   busy_f;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  int    model_count = 0;
  exp_t  sb_q[$];

  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  event_counter_bcd #(.SW_W(SW_W), .MAX_COUNT(MAX_COUNT), .DIGITS(DIGITS),
                      .DEBOUNCE_CYC(DEB)) u_dut (
    .clk100_i (clk),
    .reset    (reset),
    .key_inc_i(key_inc),
`ifdef EVCNT_DOWN_EN
    .key_dec_i(key_dec),
`endif
    .sw_i     (sw),
    .ledr_o   (ledr),
    .count_o  (count),
    .bcd_o    (bcd),
    .hex_o    (hex),
    .busy_o   (busy)
  );

  event_counter_bcd #(.SW_W(SW_W), .MAX_COUNT(MAX_COUNT), .DIGITS(DIGITS),
                      .DEBOUNCE_CYC(1)) u_fast (
    .clk100_i (clk),
    .reset    (reset),
    .key_inc_i(key_fast),
`ifdef EVCNT_DOWN_EN
    .key_dec_i(key_decf),
`endif
    .sw_i     (sw),
    .ledr_o   (ledr_f),
    .count_o  (count_f),
    .bcd_o    (bcd_f),
    .hex_o    (hex_f),
    .busy_o   (busy_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] bcd_of(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  function automatic logic [20:0] hex_of(input int v);
    return {seg_ref[(v / 100) % 10], seg_ref[(v / 10) % 10], seg_ref[v % 10]};
  endfunction

  // Monitor: timestamps count/busy/bcd changes and checks each finished conversion.
  int   t_cnt, t_rise, t_bcd;
  logic prev_busy;
  logic [CNT_W-1:0]    prev_count;
  logic [4*DIGITS-1:0] prev_bcd;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      prev_busy  = 1'b0;
      prev_count = '0;
      prev_bcd   = '0;
    end else begin
      if (count != prev_count) t_cnt = cyc;
      if (busy && !prev_busy)  t_rise = cyc;
      if (bcd != prev_bcd)     t_bcd = cyc;
      if (prev_busy && !busy) begin
        if (sb_q.size() == 0) begin
          check("unexpected_conversion", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("count", count, mon_e.count);
          check("ledr", ledr, mon_e.ledr);
          check("bcd", bcd, bcd_of(mon_e.count));
          check("hex", hex, hex_of(mon_e.count));
          check("lat_busy_rise", t_rise - t_cnt, 1);
          check("lat_bcd_update", t_bcd - t_cnt, CNT_W + 1);
          check("lat_busy_fall", cyc - t_cnt, CNT_W + 2);
        end
      end
      prev_busy  = busy;
      prev_count = count;
      prev_bcd   = bcd;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      tick(1);
      k++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic bounce(input int n_toggles);
    for (int i = 0; i < n_toggles; i++) begin
      key_inc = ~key_inc;
      tick($urandom_range(1, 3));
    end
  endtask

  // One increment press; the expected result is queued before the key moves.
  task automatic press_inc(input bit b_in, input bit b_out, input int hold);
    exp_t e;
    model_count = (model_count == MAX_COUNT) ? 0 : model_count + 1;
    e.count = model_count;
    e.ledr  = sw;
    sb_q.push_back(e);
    if (b_in) bounce(2 * $urandom_range(2, 6));
    key_inc = 1'b0;
    tick(hold);
    if (b_out) bounce(2 * $urandom_range(2, 6));
    key_inc = 1'b1;
    tick(hold);
    wait_idle();
  endtask

`ifdef EVCNT_DOWN_EN
  task automatic press_dec(input int hold);
    exp_t e;
    model_count = (model_count == 0) ? MAX_COUNT : model_count - 1;
    e.count = model_count;
    e.ledr  = sw;
    sb_q.push_back(e);
    key_dec = 1'b0;
    tick(hold);
    key_dec = 1'b1;
    tick(hold);
    wait_idle();
  endtask
`endif

  initial begin
    int k;
    int highs;
    int rises;
    logic [SW_W-1:0] led_before;
    logic busy_seen;

    // Reset state
    tick(3);
    check("rst_count", count, 0);
    check("rst_ledr", ledr, 0);
    check("rst_bcd", bcd, 0);
    check("rst_busy", busy, 0);
    check("rst_hex", hex, hex_of(0));
    reset = 1'b1;
    tick(2);

    // Single clean press, then a long hold that must not count again
    sw = 10'h2A5;
    press_inc(1'b0, 1'b0, 100);
    check("single_count", count, 1);
    check("single_ledr", ledr, 10'h2A5);
    check("single_bcd", bcd, 12'h001);

    // Bounce rejection: 10 toggles of 2 cycles, then held pressed
    sw = 10'h13C;
    begin
      exp_t e;
      model_count = model_count + 1;
      e.count = model_count;
      e.ledr  = sw;
      sb_q.push_back(e);
      for (int i = 0; i < 10; i++) begin
        key_inc = ~key_inc;
        tick(2);
      end
      key_inc = 1'b0;
      tick(40);
      key_inc = 1'b1;
      tick(HOLD);
      wait_idle();
    end
    check("bounce_count", count, 2);

    // Reach 6, then reset in the middle of the conversion to 7
    while (model_count < 6) begin
      sw = 10'($urandom);
      press_inc(1'b0, 1'b0, HOLD);
    end
    key_inc = 1'b0;
    k = 0;
    while (count != 7 && k < 100) begin tick(1); k++; end
    tick(1);
    check("abort_count7", count, 7);
    check("abort_busy1", busy, 1);
    reset   = 1'b0;
    key_inc = 1'b1;
    #1;
    check("abort_rst_count", count, 0);
    check("abort_rst_busy", busy, 0);
    check("abort_rst_bcd", bcd, 0);
    check("abort_rst_hex", hex, hex_of(0));
    @(negedge clk);
    check("abort_next_count", count, 0);
    check("abort_next_ledr", ledr, 0);
    check("abort_next_busy", busy, 0);
    tick(3);
    model_count = 0;
    sb_q.delete();
    reset = 1'b1;
    tick(2);

    // Wrap: 256 presses from 0 (press 255 shows 255, press 256 shows 000)
    for (int i = 0; i < MAX_COUNT + 1; i++) begin
      sw = 10'($urandom);
      press_inc(1'b0, 1'b0, HOLD);
    end
    check("wrap_count", count, 0);
    check("wrap_bcd", bcd, 12'h000);

`ifdef EVCNT_DOWN_EN
    // Decrement from 0 wraps to MAX_COUNT
    sw = 10'h0F0;
    press_dec(HOLD);
    check("dec_wrap_count", count, MAX_COUNT);
    check("dec_wrap_bcd", bcd, 12'h255);
    // Simultaneous presses leave everything untouched
    led_before = ledr;
    sw = 10'h3FF;
    busy_seen = 1'b0;
    key_inc = 1'b0;
    key_dec = 1'b0;
    for (int i = 0; i < 2 * HOLD; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    key_inc = 1'b1;
    key_dec = 1'b1;
    tick(HOLD);
    check("simul_count", count, MAX_COUNT);
    check("simul_ledr", ledr, led_before);
    check("simul_busy", busy_seen, 0);
`endif

    // Randomised presses with random bounce and hold lengths
    for (int i = 0; i < 24; i++) begin
      sw = 10'($urandom);
      press_inc(1'($urandom), 1'($urandom), $urandom_range(DEB + 4, DEB + 20));
    end
    check("random_count", count, model_count);

    // Pending restart on the fast-debounce instance: two presses within one conversion
    highs = 0;
    rises = 0;
    fork
      begin
        key_fast = 1'b0; tick(3);
        key_fast = 1'b1; tick(3);
        key_fast = 1'b0; tick(3);
        key_fast = 1'b1;
      end
      begin
        logic pb;
        pb = 1'b0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (busy_f) highs++;
          if (busy_f && !pb) rises++;
          pb = busy_f;
        end
      end
    join
    check("pend_rises", rises, 1);
    check("pend_busy_len", highs, 2 * (CNT_W + 1));
    check("pend_count", count_f, 2);
    check("pend_bcd", bcd_f, 12'h002);
    check("pend_hex", hex_f, hex_of(2));

    tick(5);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/event_counter_bcd.md
# event_counter_bcd

Parametrised button-event counter for the lab board. Counts debounced presses of an increment key (and, optionally, a decrement key) modulo a configurable limit. Latches the switch bank into the LED register on every count change. Drives an N-digit seven-segment display through a sequential binary-to-BCD converter. It is the next-generation version of the lab 2 press counter and sits directly between the board pins and the HEX/LEDR outputs.

## Interface

Parameters:
- SW_W, default 10: width of the switch bank and the LED register.
- MAX_COUNT, default 255: largest count value; the count wraps modulo MAX_COUNT+1. Must be at least 1.
- DIGITS, default 3: number of decimal digits shown. Must satisfy 10^DIGITS > MAX_COUNT.
- DEBOUNCE_CYC, default 1_000_000: number of consecutive stable synchronised cycles before a key level is accepted. Must be at least 1.
- CNT_W, derived as $clog2(MAX_COUNT+1): counter width. Not user-set.

Ports:
- clk100_i, input, 1: 100 MHz system clock. This is the only clock.
- reset, input, 1: asynchronous, active-low reset.
- key_inc_i, input, 1: increment key, active-low (pressed = 0), asynchronous to the clock.
- key_dec_i, input, 1: decrement key, active-low. Present only under EVCNT_DOWN_EN.
- sw_i, input, SW_W: switch bank, sampled on count change.
- ledr_o, output, SW_W: captured switch value.
- count_o, output, CNT_W: binary count.
- bcd_o, output, 4*DIGITS: packed BCD of the count. Digit 0 (units) is in bits [3:0].
- hex_o, output, 7*DIGITS: seven-segment patterns, one dec_hex decoder per BCD digit.
- busy_o, output, 1: BCD conversion in progress.

## Operation

- **Key conditioning.** Each key passes through:
  - a 2-flop synchroniser;
  - a debounce counter that accepts a new level after DEBOUNCE_CYC consecutive cycles of a stable synchronised level;
  - a press detector that emits a one-cycle press pulse on the accepted transition released→pressed.
- **One count per press.** A held key produces no further pulses. The key must be accepted as released before its next press counts.
- **Increment pulse alone:** count_o becomes (count_o == MAX_COUNT) ? 0 : count_o+1. In the same cycle, ledr_o <= sw_i.
- **Decrement pulse alone** (EVCNT_DOWN_EN only): count_o becomes (count_o == 0) ? MAX_COUNT : count_o-1. In the same cycle, ledr_o <= sw_i.
- **Both pulses in the same cycle:** count_o and ledr_o are unchanged and no conversion is requested.
- **BCD converter FSM** (IDLE, SHIFT, DONE) uses double-dabble:
  - IDLE → SHIFT on a conversion request: loads the current count_o, clears the scratch BCD, and sets shift counter = CNT_W.
  - SHIFT: each cycle adds 3 to every scratch digit ≥5, then shifts left by one. It stays in SHIFT for CNT_W cycles.
  - SHIFT → DONE: bcd_o <= scratch.
  - DONE → SHIFT if a request is pending, otherwise DONE → IDLE.
- **Pending request.** A count change while the FSM is not IDLE sets a single pending flag; multiple changes collapse into one. The restarted conversion uses the count_o value at restart time. bcd_o therefore always converges to the final count_o.
- **Display update.** bcd_o and hex_o change only in DONE, so the displayed value never shows a partial result.
- **Reset** (reset low, at any time, including mid-conversion) asynchronously forces:
  - count_o = 0, ledr_o = 0, bcd_o = 0, busy_o = 0;
  - FSM to IDLE, pending flag cleared, debouncers to the released state;
  - hex_o to the decoded pattern for "0" on every digit.

## Timing

- **Press to count.** A key edge reaches the press pulse after 2 synchroniser cycles plus DEBOUNCE_CYC cycles, ±1 cycle. count_o and ledr_o update on the clock edge after the pulse.
- **Conversion latency.** Let count_o update at edge N with the FSM in IDLE:
  - busy_o is high from edge N+1 through edge N+CNT_W+1;
  - bcd_o and hex_o update at edge N+CNT_W+1;
  - busy_o is low at N+CNT_W+2 if nothing is pending.
- **Throughput.** Presses are at least DEBOUNCE_CYC cycles apart, which is far longer than CNT_W+2, so pending restarts occur only with small DEBOUNCE_CYC in simulation.
- hex_o is combinational from bcd_o.

## Configuration

- **EVCNT_DOWN_EN defined:** the key_dec_i port, its conditioning chain and the decrement and simultaneous-press logic are compiled in.
- **EVCNT_DOWN_EN undefined:** there is no key_dec_i port and the block counts up only. Behaviour is otherwise identical.

## Structure

- **Package evcnt_pkg** holds:
  - the BCD FSM state enum (IDLE, SHIFT, DONE);
  - the localparam SYNC_STAGES = 2;
  - the function for the BCD digit add-3 correction.
- **Sub-module key_cond** is a natural split: synchroniser, debounce and press pulse. It is instantiated once per key.
- dec_hex is reused unchanged, once per digit.

## Test plan

- **Reset.** Assert reset low mid-conversion (count_o = 7, busy_o = 1) → next cycle: count_o = 0, bcd_o = 0, busy_o = 0, every hex_o digit shows "0".
- **Single press.** DEBOUNCE_CYC = 4, sw_i = 10'h2A5, one clean press of key_inc_i → count_o = 1, ledr_o = 10'h2A5, bcd_o = 12'h001 exactly CNT_W+1 cycles after count_o changes. A held key gives no second increment.
- **Bounce rejection.** Toggle key_inc_i every 2 cycles for 20 cycles, then hold it pressed → exactly one increment.
- **Wrap.** MAX_COUNT = 255: 256 presses from 0 → count_o = 0 and bcd_o = 12'h000. Press 255 shows bcd_o = 12'h255.
- **Down and simultaneous keys** (EVCNT_DOWN_EN): decrement from 0 → count_o = 255, bcd_o = 12'h255. A simultaneous inc+dec pulse → count_o and ledr_o unchanged, busy_o stays 0.
- **Pending restart.** DEBOUNCE_CYC = 1, increment twice within CNT_W cycles → one busy_o stretch of 2*(CNT_W+1) cycles, ending with bcd_o equal to the final count.
